cgra_config_master: RTL and testbench

CGRA_CONFIG_MASTER -- requirements
Module: cgra_config_master

---
 rtl/cgra_config_master_pkg.sv | 19 +
 rtl/cgra_config_master_if.sv | 24 ++
 rtl/cgra_config_master.sv | 121 ++++++++++++
 tb/tb_cgra_config_master.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cgra_config_master_pkg.sv
// Shared types and constants for the CGRA configuration master.
package cgra_config_pkg;

    localparam int CFG_ADDR_W = 32;
    localparam int CFG_DATA_W = 32;

    localparam logic       OP_WRITE  = 1'b0;
    localparam logic       OP_READ   = 1'b1;
    localparam logic [3:0] COL_BCAST = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        WAIT_RD,
        RSP
    } state_t;

endpackage

// File: rtl/cgra_config_master_if.sv
// Request/response handshake bus between a requester and the config master.
interface cgra_config_master_if;
    import cgra_config_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic                  in_op;
    logic [3:0]            in_col;
    logic [CFG_ADDR_W-1:0] in_addr;
    logic [CFG_DATA_W-1:0] in_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [CFG_DATA_W-1:0] rsp_data;

    modport master (
        output in_valid, in_op, in_col, in_addr, in_data, rsp_ready,
        input  in_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  in_valid, in_op, in_col, in_addr, in_data, rsp_ready,
        output in_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/cgra_config_master.sv
// Issues per-column config read/write strobes to a CGRA interconnect and
// returns read-back data over a valid/ready response channel.
module cgra_config_master
    import cgra_config_pkg::*;
#(
    parameter int NUM_COLS = 12,
    parameter int RD_LAT   = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    cgra_config_master_if.slave            bus,
    output logic [NUM_COLS*CFG_ADDR_W-1:0] config_addr,
    output logic [NUM_COLS*CFG_DATA_W-1:0] config_data,
    output logic [NUM_COLS-1:0]            config_read,
    output logic [NUM_COLS-1:0]            config_write,
    input  logic [CFG_DATA_W-1:0]          read_config_data,
    input  logic [NUM_COLS-1:0]            stall_in,
    output logic [NUM_COLS-1:0]            stall,
    output logic                           busy,
    output logic                           err,
    input  logic                           err_clr
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CFG_ADDR_W-1:0] r_addr;
    logic [CFG_DATA_W-1:0] r_data;
    logic [3:0]            r_col;
    logic                  r_bcast;
    logic [2:0]            r_cnt;
    logic [CFG_DATA_W-1:0] r_rsp_data;
    logic                  r_err;

    logic w_accept;
    logic w_legal_col;
    logic w_bcast;
    logic w_illegal;
    logic w_capture;

    assign w_legal_col = int'(bus.in_col) < NUM_COLS;
    assign w_bcast     = bus.in_col == COL_BCAST;
    // Broadcast is only meaningful for writes; a broadcast read has no single source.
    assign w_illegal   = !(w_legal_col || (w_bcast && bus.in_op == OP_WRITE));
    assign w_accept    = bus.in_valid && bus.in_ready;
    assign w_capture   = (r_state == WAIT_RD) && (r_cnt == 3'(RD_LAT));

    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.rsp_valid = 1'b0;
        busy          = 1'b1;
        case (r_state)
            IDLE: begin
                busy         = 1'b0;
                bus.in_ready = reset;
                if (w_accept) begin
                    if (bus.in_op == OP_READ) w_state_nxt = w_illegal ? RSP : READ;
                    else                      w_state_nxt = w_illegal ? IDLE : WRITE;
                end
            end
            WRITE:   w_state_nxt = IDLE;
            READ:    w_state_nxt = WAIT_RD;
            WAIT_RD: if (w_capture) w_state_nxt = RSP;
            RSP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_addr     <= '0;
            r_data     <= '0;
            r_col      <= '0;
            r_bcast    <= 1'b0;
            r_cnt      <= '0;
            r_rsp_data <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= bus.in_addr;
                r_data  <= bus.in_data;
                r_col   <= bus.in_col;
                r_bcast <= w_bcast;
                if (w_illegal) r_rsp_data <= '0;
            end
            // Counter is 1 in the first WAIT_RD cycle, i.e. one cycle after the strobe.
            if (r_state == READ)                r_cnt <= 3'd1;
            else if (r_state == WAIT_RD && !w_capture) r_cnt <= r_cnt + 3'd1;
            else                                r_cnt <= '0;
            if (w_capture) r_rsp_data <= read_config_data;
            if (w_accept && w_illegal) r_err <= 1'b1;
            else if (err_clr)          r_err <= 1'b0;
        end
    end

    always_comb begin
        config_write = '0;
        config_read  = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (r_bcast || r_col == 4'(c)) begin
                config_write[c] = (r_state == WRITE);
                config_read[c]  = (r_state == READ);
            end
        end
    end

    assign config_addr  = {NUM_COLS{r_addr}};
    assign config_data  = {NUM_COLS{r_data}};
    assign stall        = stall_in | {NUM_COLS{busy}};
    assign err          = r_err;
    assign bus.rsp_data = r_rsp_data;

endmodule

// File: tb/tb_cgra_config_master.sv
// Directed vector bench for cgra_config_master with a fixed-latency read-back model.
module tb_cgra_config_master;
    import cgra_config_pkg::*;

    localparam int NC  = 12;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [NC*32-1:0] config_addr, config_data;
    logic [NC-1:0]   config_read, config_write, stall_in, stall;
    logic [31:0]     read_config_data;
    logic            busy, err, err_clr;
    logic [31:0]     model_val;
    logic [1:0]      rd_pipe;

    cgra_config_master_if bus();

    cgra_config_master #(.NUM_COLS(NC), .RD_LAT(LAT)) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus.slave),
        .config_addr      (config_addr),
        .config_data      (config_data),
        .config_read      (config_read),
        .config_write     (config_write),
        .read_config_data (read_config_data),
        .stall_in         (stall_in),
        .stall            (stall),
        .busy             (busy),
        .err              (err),
        .err_clr          (err_clr)
    );

    always #5 clk = ~clk;

    // Read-back model: data valid exactly LAT cycles after the strobe cycle, garbage otherwise.
    always @(posedge clk) rd_pipe <= {rd_pipe[0], |config_read};
    assign read_config_data = rd_pipe[1] ? model_val : 32'hDEAD_BEEF;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [NC*32-1:0] act, input logic [NC*32-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        op;
        logic [3:0]  col;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdval;
        logic [11:0] exp_wr;
        logic [11:0] exp_rd;
        logic        exp_busy;
        logic        exp_err;
        logic        exp_rsp;
        int          exp_lat;
        logic [31:0] exp_rdata;
        int          hold;
    } vec_t;

    vec_t vec [10];

    initial begin
        int lat;
        vec[0] = '{OP_WRITE, 4'd3,  32'h0001_0203, 32'hA5A5_0001, 32'h0, 12'h008, 12'h000, 1, 0, 0, 0, 32'h0, 0};
        vec[1] = '{OP_WRITE, 4'hF,  32'h0000_0100, 32'hFFFF_0000, 32'h0, 12'hFFF, 12'h000, 1, 0, 0, 0, 32'h0, 0};
        vec[2] = '{OP_WRITE, 4'd0,  32'h0000_0004, 32'h0000_0011, 32'h0, 12'h001, 12'h000, 1, 0, 0, 0, 32'h0, 0};
        vec[3] = '{OP_WRITE, 4'd11, 32'h0000_0008, 32'h0000_0022, 32'h0, 12'h800, 12'h000, 1, 0, 0, 0, 32'h0, 0};
        vec[4] = '{OP_READ,  4'd7,  32'h0000_0700, 32'h0,         32'h1234_5678, 12'h000, 12'h080, 1, 0, 1, 4, 32'h1234_5678, 3};
        vec[5] = '{OP_READ,  4'd0,  32'h0000_0010, 32'h0,         32'hCAFE_F00D, 12'h000, 12'h001, 1, 0, 1, 4, 32'hCAFE_F00D, 0};
        vec[6] = '{OP_WRITE, 4'd12, 32'h0000_0C00, 32'h1111_2222, 32'h0, 12'h000, 12'h000, 0, 1, 0, 0, 32'h0, 0};
        vec[7] = '{OP_WRITE, 4'd14, 32'h0000_0E00, 32'h3333_4444, 32'h0, 12'h000, 12'h000, 0, 1, 0, 0, 32'h0, 0};
        vec[8] = '{OP_READ,  4'hF,  32'h0000_0F00, 32'h0,         32'h5555_AAAA, 12'h000, 12'h000, 1, 1, 1, 1, 32'h0, 0};
        vec[9] = '{OP_READ,  4'd13, 32'h0000_0D00, 32'h0,         32'h7777_8888, 12'h000, 12'h000, 1, 1, 1, 1, 32'h0, 1};

        reset = 1'b0; bus.in_valid = 1'b0; bus.in_op = 1'b0; bus.in_col = '0;
        bus.in_addr = '0; bus.in_data = '0; bus.rsp_ready = 1'b0;
        stall_in = '0; err_clr = 1'b0; model_val = '0; rd_pipe = '0;

        step();
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_strobes", {config_read, config_write}, 0);
        chk("rst_addr", config_addr, 0);
        chk("rst_flags", {bus.rsp_valid, busy, err}, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        step();
        reset = 1'b1;
        step();
        chk("idle_in_ready", bus.in_ready, 1);

        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1; bus.in_op = vec[i].op; bus.in_col = vec[i].col;
            bus.in_addr = vec[i].addr; bus.in_data = vec[i].data; model_val = vec[i].rdval;
            chk($sformatf("v%0d_ready", i), bus.in_ready, 1);
            step();
            bus.in_valid = 1'b0;
            chk($sformatf("v%0d_wr", i), config_write, vec[i].exp_wr);
            chk($sformatf("v%0d_rd", i), config_read, vec[i].exp_rd);
            chk($sformatf("v%0d_addr", i), config_addr, {NC{vec[i].addr}});
            chk($sformatf("v%0d_data", i), config_data, {NC{vec[i].data}});
            chk($sformatf("v%0d_busy", i), {busy, bus.in_ready}, {vec[i].exp_busy, !vec[i].exp_busy});
            chk($sformatf("v%0d_stall", i), stall, {NC{vec[i].exp_busy}});
            chk($sformatf("v%0d_err", i), err, vec[i].exp_err);
            if (vec[i].exp_rsp) begin
                lat = 1;
                while (!bus.rsp_valid && lat < 12) begin
                    step();
                    lat++;
                end
                chk($sformatf("v%0d_lat", i), lat, vec[i].exp_lat);
                chk($sformatf("v%0d_rsp", i), bus.rsp_data, vec[i].exp_rdata);
                for (int h = 0; h < vec[i].hold; h++) begin
                    step();
                    chk($sformatf("v%0d_hold%0d", i, h), {bus.rsp_valid, bus.rsp_data}, {1'b1, vec[i].exp_rdata});
                end
                bus.rsp_ready = 1'b1;
                step();
                bus.rsp_ready = 1'b0;
                chk($sformatf("v%0d_rsp_done", i), {bus.rsp_valid, busy}, 0);
            end else begin
                step();
                chk($sformatf("v%0d_after", i), {config_write, busy, bus.in_ready}, {12'h000, 1'b0, 1'b1});
            end
            err_clr = 1'b1;
            step();
            err_clr = 1'b0;
            chk($sformatf("v%0d_err_clr", i), err, 0);
        end

        // Error set and clear in the same cycle: set wins.
        bus.in_valid = 1'b1; bus.in_op = OP_WRITE; bus.in_col = 4'd13; err_clr = 1'b1;
        step();
        bus.in_valid = 1'b0; err_clr = 1'b0;
        chk("err_set_vs_clr", err, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        // External stall passes through while idle.
        stall_in = 12'h0A5;
        #1;
        chk("stall_passthru", stall, 12'h0A5);
        stall_in = '0;
        step();

        // Reset while waiting on read-back drops the response.
        bus.in_valid = 1'b1; bus.in_op = OP_READ; bus.in_col = 4'd2;
        bus.in_addr = 32'h0000_0222; model_val = 32'h9999_0000;
        step();
        bus.in_valid = 1'b0;
        chk("rr_strobe", config_read, 12'h004);
        step();
        reset = 1'b0;
        step();
        chk("rr_strobes", {config_read, config_write}, 0);
        chk("rr_addr", {config_addr[31:0], config_data[31:0]}, 0);
        chk("rr_flags", {bus.rsp_valid, bus.rsp_data, busy, err, bus.in_ready}, 0);
        reset = 1'b1;
        lat = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (bus.rsp_valid) lat++;
        end
        chk("rr_no_rsp", lat, 0);
        bus.in_valid = 1'b1; bus.in_op = OP_WRITE; bus.in_col = 4'd5;
        bus.in_addr = 32'h0000_0505; bus.in_data = 32'hBEEF_0005;
        step();
        bus.in_valid = 1'b0;
        chk("rr_next_write", {config_write, config_data[32*5 +: 32]}, {12'h020, 32'hBEEF_0005});
        step();
        chk("rr_next_idle", {config_write, busy}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
